vram_arbiter: RTL and testbench

Shares the single-port synchronous video RAM (14-bit address, 12-bit data) between two requesters.
- The scanout video generator has absolute priority, fixed latency and is never stalled.
- The CPU bus gets leftover cycles through a req/ack handshake, with a one-entry posted write buffer.
- Sits between the video generator, the CPU memory interface and the video RAM macro.

---
 rtl/vram_arbiter_pkg.sv | 23 ++
 rtl/vram_arbiter_if.sv | 40 ++++
 rtl/vram_arbiter.sv | 107 ++++++++++
 tb/tb_vram_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared video package for the VRAM arbiter.
// Holds the default RAM geometry (14-bit address, 12-bit data), the CPU-side
// FSM state encoding and the per-cycle RAM grant encoding.
package vram_arbiter_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_DATA = 2'd1,
    ACK     = 2'd2
  } cpu_state_e;

  // Owner of the single RAM port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_VID    = 2'd1,
    GNT_DRAIN  = 2'd2,
    GNT_CPU_RD = 2'd3
  } grant_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle around the VRAM arbiter.
//   video side : vid_req, vid_addr -> vid_data, vid_valid
//   cpu side   : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_ack, cpu_rdata, wbuf_full
//   ram side   : mem_addr, mem_we, mem_wdata -> mem_rdata
// Modport slave is the arbiter; modport master is everything around it
// (video generator, CPU and RAM macro together).
interface vram_arbiter_if #(
  parameter int ADDR_W = vram_arbiter_pkg::ADDR_W,
  parameter int DATA_W = vram_arbiter_pkg::DATA_W
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              wbuf_full;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vid_data, vid_valid, cpu_ack, cpu_rdata, wbuf_full,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vid_data, vid_valid, cpu_ack, cpu_rdata, wbuf_full,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port synchronous video RAM between the
// scanout video generator and the CPU bus.
//   clk : system/pixel clock
//   rst : asynchronous, active-low reset
//   bus : vram_arbiter_if.slave (video read port, CPU req/ack port with a
//         one-entry posted write buffer, RAM macro port)
// Video always wins the RAM and sees a fixed 1-cycle read latency. The CPU
// uses leftover cycles: writes are posted into the buffer and acked at once,
// reads issue only when the buffer is empty, so no forwarding is needed.
module vram_arbiter
  import vram_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  vram_arbiter_if.slave  bus
);

  cpu_state_e        state;
  grant_e            gnt;

  logic              wb_vld;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              vid_valid_q;
  logic              cpu_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  logic [ADDR_W-1:0] mem_addr_c;
  logic              mem_we_c;

  // Grant priority: video, then drain, then CPU read. Held off during reset
  // so the RAM port idles at address 0.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst)                                          gnt = GNT_NONE;
    else if (bus.vid_req)                              gnt = GNT_VID;
    else if (wb_vld)                                   gnt = GNT_DRAIN;
    else if (state == IDLE && bus.cpu_req && !bus.cpu_we) gnt = GNT_CPU_RD;
  end

  always_comb begin
    mem_addr_c = '0;
    mem_we_c   = 1'b0;
    case (gnt)
      GNT_VID:    mem_addr_c = bus.vid_addr;
      GNT_DRAIN:  begin mem_addr_c = wb_addr; mem_we_c = 1'b1; end
      GNT_CPU_RD: mem_addr_c = bus.cpu_addr;
      default:    mem_addr_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wb_vld      <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      vid_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      vid_valid_q <= bus.vid_req;
      cpu_ack_q   <= 1'b0;

      // Drain needs a full buffer and fill needs an empty one, so the two
      // never collide in the same cycle.
      if (gnt == GNT_DRAIN) wb_vld <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            if (bus.cpu_we) begin
              // A write meeting a full buffer simply waits, unlatched.
              if (!wb_vld) begin
                wb_vld    <= 1'b1;
                wb_addr   <= bus.cpu_addr;
                wb_data   <= bus.cpu_wdata;
                cpu_ack_q <= 1'b1;
                state     <= ACK;
              end
            end else if (gnt == GNT_CPU_RD) begin
              state <= RD_DATA;
            end
          end
        end
        RD_DATA: begin
          cpu_rdata_q <= bus.mem_rdata;
          cpu_ack_q   <= 1'b1;
          state       <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vid_data  = bus.mem_rdata;
  assign bus.vid_valid = vid_valid_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.wbuf_full = wb_vld;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_wdata = wb_data;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: behavioural synchronous RAM, directed stimulus,
// scoreboard queues for video reads and CPU acks checked by a negedge monitor.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if bus();

  vram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Preload pattern: address low 12 bits XOR 0x5A5.
  function automatic logic [11:0] init_val(logic [13:0] a);
    return a[11:0] ^ 12'h5A5;
  endfunction

  // RAM macro model: read data appears the cycle after the address.
  logic [11:0] ram [0:16383];
  initial for (int i = 0; i < 16384; i++) ram[i] = init_val(14'(i));
  always @(posedge clk) begin
    bus.mem_rdata <= ram[bus.mem_addr];
    if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
  end

  typedef struct packed {
    logic        is_rd;
    logic [11:0] rdata;
  } cpu_exp_t;

  logic [11:0] vq[$];
  cpu_exp_t    cq[$];
  logic [25:0] wlog[$];
  logic        prev_vreq = 1'b0;
  int          cyc = 0;
  int          ack_cnt = 0;
  int          last_ack_cyc = -1;
  int          last_we_cyc = -1;

  // Expected video data is pushed when the request is sampled.
  always @(posedge clk) begin
    cyc++;
    prev_vreq = rst && bus.vid_req;
    if (rst && bus.vid_req) vq.push_back(init_val(bus.vid_addr));
  end

  cpu_exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      vq.delete();
    end else begin
      check("vid_valid", bus.vid_valid, prev_vreq);
      if (bus.vid_valid) begin
        if (vq.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL vid_data: valid with empty scoreboard, got 0x%0h", bus.vid_data);
        end else check("vid_data", bus.vid_data, vq.pop_front());
      end
      if (bus.cpu_ack) begin
        ack_cnt++;
        last_ack_cyc = cyc;
        if (cq.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL cpu_ack: unexpected ack, got 1 expected 0");
        end else begin
          e = cq.pop_front();
          if (e.is_rd) check("cpu_rdata", bus.cpu_rdata, e.rdata);
        end
      end
      if (bus.mem_we) begin
        last_we_cyc = cyc;
        wlog.push_back({bus.mem_addr, bus.mem_wdata});
        check("we_during_vid", bus.vid_req, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic vid_burst(int n, logic [13:0] base);
    for (int i = 0; i < n; i++) begin
      bus.vid_req  = 1'b1;
      bus.vid_addr = base + 14'(i % 5);
      tick();
    end
    bus.vid_req = 1'b0;
  endtask

  // Latency counts cycles from presenting the request to the ACK cycle.
  task automatic cpu_op(bit we, logic [13:0] a, logic [11:0] d, int exp_lat, string name);
    int n;
    cpu_exp_t x;
    n = 0;
    x.is_rd = !we;
    x.rdata = d;
    cq.push_back(x);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = we ? d : 12'h000;
    while (n < 200) begin
      tick();
      n++;
      if (bus.cpu_ack) break;
    end
    bus.cpu_req = 1'b0;
    check({name, "_lat"}, n, exp_lat);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    bus.vid_req   = 1'b1;
    bus.vid_addr  = 14'h0100;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    #1 rst = 1'b0;
    repeat (3) tick();

    // Reset state, with a video request pending that must not reach the RAM.
    check("rst_cpu_ack",   bus.cpu_ack,   0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_vid_valid", bus.vid_valid, 0);
    check("rst_wbuf_full", bus.wbuf_full, 0);
    check("rst_mem_we",    bus.mem_we,    0);
    check("rst_mem_addr",  bus.mem_addr,  0);
    bus.vid_req = 1'b0;
    rst = 1'b1;
    tick();

    // Video only.
    vid_burst(5, 14'h0100);
    repeat (2) tick();
    check("vid_only_no_we", last_we_cyc, -1);

    // CPU write then read, video idle.
    cpu_op(1'b1, 14'h1234, 12'h2A5, 1, "wr1");
    check("wr1_we_cycle", last_we_cyc, last_ack_cyc);
    check("wr1_ram", ram[14'h1234], 12'h2A5);
    cpu_op(1'b0, 14'h1234, 12'h2A5, 2, "rd1");

    // Video blocks a pending CPU read for 20 cycles.
    fork
      vid_burst(20, 14'h0100);
      cpu_op(1'b0, 14'h1234, 12'h2A5, 22, "rd_blk");
    join
    tick();

    // Back-to-back writes under video load.
    wlog.delete();
    fork
      vid_burst(10, 14'h0100);
      begin
        cpu_op(1'b1, 14'h0010, 12'hABC, 1, "bb_w1");
        cpu_op(1'b1, 14'h0011, 12'h123, 10, "bb_w2");
      end
      begin
        repeat (5) tick();
        check("bb_wbuf_full_a", bus.wbuf_full, 1);
        repeat (3) tick();
        check("bb_wbuf_full_b", bus.wbuf_full, 1);
      end
    join
    check("bb_wr_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("bb_wr_first",  wlog[0], {14'h0010, 12'hABC});
      check("bb_wr_second", wlog[1], {14'h0011, 12'h123});
    end

    // Read right after a posted write to the same address, video busy.
    fork
      vid_burst(6, 14'h0102);
      begin
        cpu_op(1'b1, 14'h0003, 12'h7FF, 1, "raw_w");
        cpu_op(1'b0, 14'h0003, 12'h7FF, 7, "raw_r");
      end
    join
    tick();

    // Reset with a posted write still in the buffer.
    bus.vid_req  = 1'b1;
    bus.vid_addr = 14'h0100;
    cpu_op(1'b1, 14'h0020, 12'h555, 1, "rst_w");
    check("pre_rst_wbuf_full", bus.wbuf_full, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_cpu_rdata", bus.cpu_rdata, 0);
    check("mid_rst_vid_valid", bus.vid_valid, 0);
    check("mid_rst_wbuf_full", bus.wbuf_full, 0);
    check("mid_rst_mem_addr",  bus.mem_addr,  0);
    check("mid_rst_mem_we",    bus.mem_we,    0);
    tick();
    rst = 1'b1;
    bus.vid_req = 1'b0;
    repeat (3) tick();
    check("rst_discard_ram", ram[14'h0020], 12'h585);

    // Reset with a read in RD_DATA: no ack may follow.
    a0 = ack_cnt;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 14'h1234;
    tick();
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    check("rd_rst_cpu_ack", bus.cpu_ack, 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (4) tick();
    check("rd_rst_no_ack", ack_cnt, a0);
    check("rd_rst_rdata",  bus.cpu_rdata, 0);

    check("scoreboard_drained", cq.size() + vq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
